// File: rtl/er_scheduler.sv
// Round-robin scheduler that shares the Earthrise drawing engine between requesters.
// It grants one job at a time, can hold the start until a frame boundary, and watches for timeout.
module er_scheduler #(
    parameter int REQS      = 2,
    parameter int ADDRW     = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic [REQS-1:0]         req,
    input  logic [REQS*ADDRW-1:0]   req_addr,
    input  logic [REQS-1:0]         req_sync,
    output logic [REQS-1:0]         grant,
    output logic [REQS-1:0]         done,
    input  logic                    frame,
    input  logic                    er_busy,
    input  logic                    er_done,
    output logic                    er_start,
    output logic [ADDRW-1:0]        er_addr,
    output logic                    busy,
    output logic                    timeout
);
    localparam int IW = (REQS > 1) ? $clog2(REQS) : 1;
    // The watchdog fires on the edge where the count steps from max-1 to max.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_RUN} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_last;
    logic [REQS-1:0]        r_owner;
    logic                   r_sync;
    logic [TIMEOUT_W-1:0]   r_wd;
    logic [REQS-1:0]        r_grant;
    logic [REQS-1:0]        r_done;
    logic                   r_start;
    logic [ADDRW-1:0]       r_addr;
    logic                   r_busy;
    logic                   r_timeout;

    logic [IW:0]            w_cand;
    logic [IW-1:0]          w_idx;
    logic                   w_vld;
    logic [REQS-1:0]        w_oh;
    logic [ADDRW-1:0]       w_addr;
    logic                   w_sync;

    // Search from last+1 upward with wrap; the first set request wins.
    always_comb begin
        w_vld  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 1; k <= REQS; k++) begin
            w_cand = {1'b0, r_last} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(REQS))
                w_cand = w_cand - (IW+1)'(REQS);
            if (!w_vld && req[w_cand[IW-1:0]]) begin
                w_vld = 1'b1;
                w_idx = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        w_oh   = '0;
        w_addr = '0;
        w_sync = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            if (w_vld && w_idx == IW'(i)) begin
                w_oh[i] = 1'b1;
                w_addr  = req_addr[i*ADDRW +: ADDRW];
                w_sync  = req_sync[i];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_state   <= S_IDLE;
            r_last    <= IW'(REQS-1);
            r_owner   <= '0;
            r_sync    <= 1'b0;
            r_wd      <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_start   <= 1'b0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_grant   <= '0;
            r_done    <= '0;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_vld) begin
                        r_state <= S_WAIT;
                        r_owner <= w_oh;
                        r_grant <= w_oh;
                        r_addr  <= w_addr;
                        r_sync  <= w_sync;
                        r_last  <= w_idx;
                        r_busy  <= 1'b1;
                    end
                end
                // A frame seen while the engine is busy is dropped, not remembered.
                S_WAIT: begin
                    if ((!r_sync || frame) && !er_busy)
                        r_state <= S_START;
                end
                S_START: begin
                    r_start <= 1'b1;
                    r_wd    <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_wd <= r_wd + TIMEOUT_W'(1);
                    if (er_done || r_wd == WD_LAST) begin
                        r_done    <= r_owner;
                        r_timeout <= !er_done;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign er_start = r_start;
    assign er_addr  = r_addr;
    assign busy     = r_busy;
    assign timeout  = r_timeout;
endmodule

// File: tb/tb_er_scheduler.sv
// Bench for er_scheduler: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a timestamp-based job model.
module tb_er_scheduler;
    localparam int REQS = 2;
    localparam int AW   = 16;
    localparam int TW   = 4;

    logic             clk_sys = 1'b0;
    logic             rst_sys = 1'b1;
    logic [REQS-1:0]  req = '0;
    logic [REQS*AW-1:0] req_addr = '0;
    logic [REQS-1:0]  req_sync = '0;
    logic [REQS-1:0]  grant, done;
    logic             frame = 1'b0, er_busy = 1'b0, er_done = 1'b0;
    logic             er_start, busy, timeout;
    logic [AW-1:0]    er_addr;

    int checks = 0;
    int errors = 0;

    er_scheduler #(.REQS(REQS), .ADDRW(AW), .TIMEOUT_W(TW)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .req(req), .req_addr(req_addr),
        .req_sync(req_sync), .grant(grant), .done(done), .frame(frame),
        .er_busy(er_busy), .er_done(er_done), .er_start(er_start),
        .er_addr(er_addr), .busy(busy), .timeout(timeout)
    );

    always #5 clk_sys = ~clk_sys;

    // Job model: one outstanding job, described by the edges at which it was granted,
    // qualified to start, and started. RUN edge n is simply (cycle - start edge).
    int cyc = 0;
    int m_last = REQS-1;
    bit m_act = 0;
    int m_qual = -1;
    int m_start = -1;
    int m_owner = 0;
    bit m_sync = 0;
    int cand, win, n;
    logic [REQS-1:0] e_grant = '0, e_done = '0;
    logic e_start = 0, e_to = 0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            m_last = REQS-1; m_act = 0; m_qual = -1; m_start = -1; m_addr = '0;
            e_grant = '0; e_done = '0; e_start = 0; e_to = 0;
        end else begin
            cyc = cyc + 1;
            e_grant = '0; e_done = '0; e_start = 0; e_to = 0;
            if (!m_act) begin
                win = -1;
                for (int k = 1; k <= REQS; k++) begin
                    cand = (m_last + k) % REQS;
                    if (win < 0 && ((req >> cand) & 1) != 0) win = cand;
                end
                if (win >= 0) begin
                    m_act = 1; m_owner = win; m_last = win;
                    m_addr = AW'(req_addr >> (win*AW));
                    m_sync = ((req_sync >> win) & 1) != 0;
                    m_qual = -1; m_start = -1;
                    e_grant = REQS'(1 << win);
                end
            end else if (m_qual < 0) begin
                if ((!m_sync || frame) && !er_busy) m_qual = cyc;
            end else if (m_start < 0) begin
                m_start = cyc;
                e_start = 1;
            end else begin
                n = cyc - m_start;
                if (er_done || n == (1 << TW) - 1) begin
                    e_done = REQS'(1 << m_owner);
                    e_to = !er_done;
                    m_act = 0;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        checks++;
        if (grant !== e_grant || done !== e_done || er_start !== e_start ||
            timeout !== e_to || busy !== m_act || er_addr !== m_addr) begin
            errors++;
            $display("FAIL model t=%0t got g=%b d=%b s=%b to=%b b=%b a=%h want g=%b d=%b s=%b to=%b b=%b a=%h",
                     $time, grant, done, er_start, timeout, busy, er_addr,
                     e_grant, e_done, e_start, e_to, m_act, m_addr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk_sys);
    endtask

    // sel: 0 = grant, 1 = er_start, 2 = done
    task automatic wait_out(input int sel, input string nm);
        bit hit = 0;
        for (int t = 0; t < 60 && !hit; t++) begin
            nx();
            case (sel)
                0:       hit = |grant;
                1:       hit = er_start;
                default: hit = |done;
            endcase
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s wait expired got 0 want 1", nm);
        end
    endtask

    task automatic finish_job(input logic [1:0] owner, input string nm);
        er_done = 1'b1;
        nx();
        er_done = 1'b0;
        chk(nm, 32'(done), 32'(owner));
    endtask

    initial begin
        repeat (3) nx();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(er_addr), 0);
        chk("rst_start", 32'(er_start), 0);
        rst_sys = 1'b0;
        nx();

        // Single requester, no sync
        req = 2'b01; req_addr = 32'h0000_0040;
        nx();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_busy", 32'(busy), 1);
        req = 2'b00;
        nx();
        chk("single_nostart", 32'(er_start), 0);
        nx();
        chk("single_start", 32'(er_start), 1);
        chk("single_addr", 32'(er_addr), 32'h40);
        repeat (4) nx();
        finish_job(2'b01, "single_done");
        chk("single_idle", 32'(busy), 0);

        // Round robin, both held; last owner was 0 so 1 goes next
        req = 2'b11; req_addr = {16'h2222, 16'h1111};
        for (int j = 0; j < 4; j++) begin
            wait_out(0, "rr_grant_wait");
            chk("rr_grant", 32'(grant), (j % 2 == 0) ? 32'h2 : 32'h1);
            if (j == 3) req = 2'b00;
            wait_out(1, "rr_start_wait");
            chk("rr_addr", 32'(er_addr), (j % 2 == 0) ? 32'h2222 : 32'h1111);
            nx();
            finish_job((j % 2 == 0) ? 2'b10 : 2'b01, "rr_done");
        end

        // Frame sync: first frame lands while the engine is busy
        req = 2'b10; req_sync = 2'b10; req_addr = {16'hABCD, 16'h0};
        wait_out(0, "sync_grant_wait");
        req = 2'b00;
        frame = 1'b1; er_busy = 1'b1;
        nx();
        frame = 1'b0; er_busy = 1'b0;
        for (int t = 0; t < 18; t++) begin
            nx();
            chk("sync_hold", 32'(er_start), 0);
        end
        frame = 1'b1;
        nx();
        frame = 1'b0;
        chk("sync_not_yet", 32'(er_start), 0);
        nx();
        chk("sync_start", 32'(er_start), 1);
        chk("sync_addr", 32'(er_addr), 32'hABCD);
        req_sync = 2'b00;
        nx();
        finish_job(2'b10, "sync_done");

        // Watchdog timeout after 15 RUN edges
        req = 2'b01; req_addr = 32'h0000_0777;
        wait_out(0, "wd_grant_wait");
        req = 2'b00;
        wait_out(1, "wd_start_wait");
        for (int t = 1; t <= 14; t++) begin
            nx();
            chk("wd_early", 32'(done), 0);
        end
        nx();
        chk("wd_done", 32'(done), 32'h1);
        chk("wd_timeout", 32'(timeout), 1);
        chk("wd_idle", 32'(busy), 0);

        // er_done on the 15th RUN edge wins over timeout
        req = 2'b01;
        wait_out(0, "wd2_grant_wait");
        req = 2'b00;
        wait_out(1, "wd2_start_wait");
        repeat (14) nx();
        er_done = 1'b1;
        nx();
        er_done = 1'b0;
        chk("wd2_done", 32'(done), 32'h1);
        chk("wd2_timeout", 32'(timeout), 0);

        // Spurious er_done in IDLE and during START
        er_done = 1'b1;
        nx();
        er_done = 1'b0;
        chk("idle_edone", 32'(done), 0);
        req = 2'b01;
        wait_out(0, "sp_grant_wait");
        req = 2'b00;
        nx();
        er_done = 1'b1;
        nx();
        er_done = 1'b0;
        chk("sp_start", 32'(er_start), 1);
        chk("sp_nodone", 32'(done), 0);
        repeat (2) nx();
        chk("sp_still_busy", 32'(busy), 1);
        finish_job(2'b01, "sp_done");

        // Asynchronous reset in the middle of RUN
        req = 2'b01;
        wait_out(0, "rst_grant_wait");
        req = 2'b00;
        wait_out(1, "rst_start_wait");
        #2 rst_sys = 1'b1;
        #1;
        chk("arst_start", 32'(er_start), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_addr", 32'(er_addr), 0);
        nx();
        rst_sys = 1'b0;
        nx();
        chk("arst_nodone", 32'(done), 0);
        req = 2'b10;
        wait_out(0, "arst_grant_wait");
        chk("arst_grant", 32'(grant), 32'h2);
        req = 2'b00;
        wait_out(1, "arst_start2_wait");
        nx();
        finish_job(2'b10, "arst_done");

        // Random traffic against the model
        for (int t = 0; t < 4000; t++) begin
            nx();
            req      = REQS'($urandom);
            req_addr = $urandom;
            req_sync = REQS'($urandom);
            frame    = ($urandom % 8) == 0;
            er_busy  = ($urandom % 4) == 0;
            er_done  = ($urandom % 7) == 0;
        end
        nx();
        req = '0; frame = 0; er_busy = 0; er_done = 0;
        repeat (40) nx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
